processor_datapath: RTL and testbench
=====================================

# processor_datapath

Datapath for the 16-bit multicycle processor, directly downstream of the control unit. It consumes every control signal the control unit emits per step and returns the instruction word, the step count and the G register. It contains:
- R0..R7 register file, with R7 serving as PC.
- A and G registers, ALU and shared bus.
- Instruction register, 2-bit step counter.
- Memory-side ADDR, DOUT and W registers.

## Interface
- N, 16, datapath/bus width.

- Clock  in  1  rising-edge clock.
- Resetn  in  1  reset, synchronous, active-low.
- DIN  in  N  data/instruction word from memory.
- Run  in  1  start-of-instruction request to step counter.
- Clear  in  1  synchronous clear of step counter.
- IncrPc  in  1  increment R7 at next edge.
- IRin  in  1  load IR from DIN[8:0].
- Rin  in  8  Rin[i] loads Ri from bus.
- Rout  in  8  Rout[i] drives Ri onto bus.
- Ain  in  1  load A from bus.
- Gin  in  1  load G from ALU result.
- Gout  in  1  drive G onto bus.
- Ulaop  in  2  ALU operation select.
- DINout  in  1  drive DIN onto bus.
- ADDRin  in  1  load ADDR.
- DOUTin  in  1  load DOUT from bus.
- W_D  in  1  memory write request, registered to W.
- Instrucao  out  9  IR contents, fed to control unit.
- Tstep  out  2  current step, fed to control unit.
- GRout  out  N  G register contents, fed to control unit (mvnz test).
- BusWires  out  N  current bus value, for debug.
- ADDR  out  N  memory address register.
- DOUT  out  N  memory write-data register.
- W  out  1  registered memory write enable.

## Operation
- Bus is combinational, with fixed priority: DINout > Gout > Rout[0] > … > Rout[7]. With no source selected, the bus is 0.
- ALU is combinational, computing A op Bus, truncated to N bits, no carry/flags:
  - 00 = add
  - 01 = sub, two's-complement wrap
  - 10 = bitwise AND
  - 11 = pass A
- On each rising edge with Resetn=1:
  - Rin[i]: Ri ← bus. Multiple Rin bits load all selected registers.
  - IncrPc: R7 ← R7+1, wrapping FFFF→0000. If Rin[7] is asserted in the same cycle, the Rin load wins and no increment occurs.
  - Ain: A ← bus.
  - Gin: G ← ALU result, using the A value held before this edge.
  - IRin: IR ← DIN[8:0].
  - ADDRin: ADDR ← bus if any bus source is selected, else ADDR ← R7 (fetch path).
  - DOUTin: DOUT ← bus.
  - W ← W_D every cycle.
- Step counter:
  - Clear=1 forces Tstep←00, with priority over counting.
  - Otherwise it increments when Run=1 or Tstep≠00, and holds at 00 when idle.
  - 11 wraps to 00.
- Unselected registers hold their value.

## Timing
- Resetn=0 at an edge clears everything at that edge, regardless of any other input and including mid-instruction:
  - R0..R7, A, G, IR, ADDR, DOUT all 0.
  - W=0, Tstep=00.
- The reset above gives these output values: Instrucao=0, Tstep=00, GRout=0, ADDR=0, DOUT=0, W=0. BusWires is then 0 unless DIN is driven with DINout=1.
- All register updates take one cycle. A value written by Rin at edge k is visible on Ri, and on the bus via Rout, from cycle k+1.
- Control signals are sampled only at the rising edge. BusWires, ALU output and GRout-dependent decisions are valid within the same cycle.
- sub sequence, three cycles:
  - T1: Rout[x]+Ain
  - T2: Rout[y]+Ulaop=01+Gin
  - T3: Gout+Rin[x]
  - The result appears in Rx one edge after T3.
- Tstep follows control-unit Clear at the same edge, so the next instruction starts at T0 in the cycle after Done.

## Test plan
- Load R3=0x1234 via DINout/Rin[3], then hold Resetn=0 for one edge with Run=1, DINout=1 -> all registers 0, Tstep=00, W=0 after that edge.
- DIN=0x00A5, DINout=1, Rin=0000_0100 -> BusWires=0x00A5 in the same cycle; R2=0x00A5 after the edge; other registers unchanged.
- sub sequence, first case: R1=7, R2=3, run the three-cycle sequence -> GRout=0x0004 after T2, R1=0x0004 after T3.
- sub sequence, second case: R1=3, R2=7 -> R1=0xFFFC.
- Run pulsed one cycle -> Tstep 00,01,10,11,00 then stays 00. Repeat with Clear=1 while Tstep=01 -> Tstep=00 at next edge.
- R7=0xFFFF, IncrPc=1 -> R7=0x0000. R7=5 with IncrPc=1, Rin[7]=1, DINout=1, DIN=0x0040 -> R7=0x0040.
- DIN=0x01CB, IRin=1, ADDRin=1, no bus source, R7=0x0010 -> Instrucao=9'h1CB, ADDR=0x0010. Then Rout[4]=1 with R4=0x0033, ADDRin=1, DOUTin=1, W_D=1 -> ADDR=DOUT=0x0033, W=1 after the edge.

Source files
------------

// File: rtl/processor_datapath.sv
// processor_datapath: register file, A/G, ALU, shared bus, IR, step counter and memory-side registers
module processor_datapath #(
    parameter int N = 16
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic [N-1:0] DIN,
    input  logic         Run,
    input  logic         Clear,
    input  logic         IncrPc,
    input  logic         IRin,
    input  logic [7:0]   Rin,
    input  logic [7:0]   Rout,
    input  logic         Ain,
    input  logic         Gin,
    input  logic         Gout,
    input  logic [1:0]   Ulaop,
    input  logic         DINout,
    input  logic         ADDRin,
    input  logic         DOUTin,
    input  logic         W_D,
    output logic [8:0]   Instrucao,
    output logic [1:0]   Tstep,
    output logic [N-1:0] GRout,
    output logic [N-1:0] BusWires,
    output logic [N-1:0] ADDR,
    output logic [N-1:0] DOUT,
    output logic         W
);
    logic [N-1:0] r_reg [8];
    logic [N-1:0] r_a, r_g, r_addr, r_dout;
    logic [8:0]   r_ir;
    logic [1:0]   r_tstep;
    logic         r_w;
    logic [N-1:0] w_bus, w_alu;
    logic         w_src;
    // lowest-numbered Rout wins among registers; G and DIN override in that order
    always_comb begin
        w_bus = '0;
        for (int i = 7; i >= 0; i--)
            if (Rout[i]) w_bus = r_reg[i];
        if (Gout) w_bus = r_g;
        if (DINout) w_bus = DIN;
    end
    assign w_src = DINout | Gout | (|Rout);
    assign w_alu = (Ulaop == 2'b00) ? r_a + w_bus :
                   (Ulaop == 2'b01) ? r_a - w_bus :
                   (Ulaop == 2'b10) ? r_a & w_bus : r_a;
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            for (int i = 0; i < 8; i++) r_reg[i] <= '0;
            r_a     <= '0;
            r_g     <= '0;
            r_ir    <= '0;
            r_addr  <= '0;
            r_dout  <= '0;
            r_w     <= 1'b0;
            r_tstep <= 2'b00;
        end else begin
            for (int i = 0; i < 8; i++)
                if (Rin[i]) r_reg[i] <= w_bus;
            if (IncrPc && !Rin[7]) r_reg[7] <= r_reg[7] + N'(1);
            if (Ain) r_a <= w_bus;
            if (Gin) r_g <= w_alu;
            if (IRin) r_ir <= DIN[8:0];
            // with nothing on the bus, ADDR takes the PC for instruction fetch
            if (ADDRin) r_addr <= w_src ? w_bus : r_reg[7];
            if (DOUTin) r_dout <= w_bus;
            r_w     <= W_D;
            r_tstep <= Clear ? 2'b00 : (Run || r_tstep != 2'b00) ? r_tstep + 2'd1 : r_tstep;
        end
    end
    assign Instrucao = r_ir;
    assign Tstep     = r_tstep;
    assign GRout     = r_g;
    assign BusWires  = w_bus;
    assign ADDR      = r_addr;
    assign DOUT      = r_dout;
    assign W         = r_w;
endmodule

// File: tb/tb_processor_datapath.sv
// tb_processor_datapath: directed and random checks of processor_datapath against a behavioural model
`timescale 1ns/1ps
module tb_processor_datapath;
    logic        Clock, Resetn, Run, Clear, IncrPc, IRin, Ain, Gin, Gout, DINout, ADDRin, DOUTin, W_D;
    logic [15:0] DIN;
    logic [7:0]  Rin, Rout;
    logic [1:0]  Ulaop;
    logic [8:0]  Instrucao;
    logic [1:0]  Tstep;
    logic [15:0] GRout, BusWires, ADDR, DOUT;
    logic        W;
    int total = 0, bad = 0;
    logic [15:0] m_r [8];
    logic [15:0] m_a, m_g, m_addr, m_dout;
    logic [8:0]  m_ir;
    logic        m_w;
    int          m_t;

    processor_datapath dut (
        .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .Run(Run), .Clear(Clear), .IncrPc(IncrPc),
        .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin), .Gout(Gout), .Ulaop(Ulaop),
        .DINout(DINout), .ADDRin(ADDRin), .DOUTin(DOUTin), .W_D(W_D), .Instrucao(Instrucao),
        .Tstep(Tstep), .GRout(GRout), .BusWires(BusWires), .ADDR(ADDR), .DOUT(DOUT), .W(W)
    );

    initial Clock = 0;
    always #20 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mbus();
        if (DINout) return DIN;
        if (Gout) return m_g;
        for (int i = 0; i < 8; i++)
            if (Rout[i]) return m_r[i];
        return 16'h0;
    endfunction

    task automatic clr();
        DIN = 0; Run = 0; Clear = 0; IncrPc = 0; IRin = 0; Rin = 0; Rout = 0; Ain = 0;
        Gin = 0; Gout = 0; Ulaop = 0; DINout = 0; ADDRin = 0; DOUTin = 0; W_D = 0;
    endtask

    task automatic cyc();
        logic [15:0] b, alu, pc;
        #1 b = mbus();
        chk("bus", BusWires, b);
        case (Ulaop)
            2'd0: alu = m_a + b;
            2'd1: alu = m_a - b;
            2'd2: alu = m_a & b;
            default: alu = m_a;
        endcase
        pc = m_r[7];
        @(posedge Clock);
        if (!Resetn) begin
            for (int i = 0; i < 8; i++) m_r[i] = 0;
            m_a = 0; m_g = 0; m_ir = 0; m_addr = 0; m_dout = 0; m_w = 0; m_t = 0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (Rin[i]) m_r[i] = b;
            if (IncrPc && !Rin[7]) m_r[7] = pc + 16'd1;
            if (Ain) m_a = b;
            if (Gin) m_g = alu;
            if (IRin) m_ir = DIN[8:0];
            if (ADDRin) m_addr = (DINout || Gout || Rout != 0) ? b : pc;
            if (DOUTin) m_dout = b;
            m_w = W_D;
            if (Clear) m_t = 0;
            else if (Run || m_t != 0) m_t = (m_t + 1) % 4;
        end
        @(negedge Clock);
        chk("tstep", 16'(Tstep), 16'(m_t));
        chk("grout", GRout, m_g);
        chk("ir", 16'(Instrucao), 16'(m_ir));
        chk("addr", ADDR, m_addr);
        chk("dout", DOUT, m_dout);
        chk("w", 16'(W), 16'(m_w));
    endtask

    task automatic pkc(input int i, input logic [15:0] exp);
        Rout = 8'(1 << i);
        #1 chk($sformatf("R%0d", i), BusWires, exp);
        Rout = 0;
    endtask

    task automatic peek_all();
        for (int i = 0; i < 8; i++) pkc(i, m_r[i]);
    endtask

    task automatic load(input int r, input logic [15:0] v);
        clr(); DIN = v; DINout = 1; Rin = 8'(1 << r);
        cyc();
        clr();
    endtask

    task automatic do_sub(input logic [15:0] x, input logic [15:0] y, input logic [15:0] res);
        load(1, x); load(2, y);
        Rout = 8'h02; Ain = 1; cyc(); clr();
        Rout = 8'h04; Ulaop = 2'b01; Gin = 1; cyc(); clr();
        chk("sub_g", GRout, res);
        Gout = 1; Rin = 8'h02; cyc(); clr();
        pkc(1, res);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_a = 0; m_g = 0; m_ir = 0; m_addr = 0; m_dout = 0; m_w = 0; m_t = 0;
        clr(); Resetn = 0;
        cyc();
        Resetn = 1;
        load(3, 16'h1234);
        pkc(3, 16'h1234);
        Resetn = 0; Run = 1; DINout = 1; DIN = 16'hFFFF;
        cyc();
        Resetn = 1; clr();
        chk("rst_tstep", 16'(Tstep), 16'h0);
        chk("rst_w", 16'(W), 16'h0);
        pkc(3, 16'h0000);
        peek_all();
        DIN = 16'h00A5; DINout = 1; Rin = 8'b0000_0100;
        #1 chk("bus_a5", BusWires, 16'h00A5);
        cyc(); clr();
        pkc(2, 16'h00A5);
        peek_all();
        do_sub(16'd7, 16'd3, 16'h0004);
        do_sub(16'd3, 16'd7, 16'hFFFC);
        Run = 1; cyc(); clr();
        chk("t1", 16'(Tstep), 16'd1);
        cyc(); chk("t2", 16'(Tstep), 16'd2);
        cyc(); chk("t3", 16'(Tstep), 16'd3);
        cyc(); chk("t0", 16'(Tstep), 16'd0);
        cyc(); chk("tidle", 16'(Tstep), 16'd0);
        Run = 1; cyc(); clr();
        Clear = 1; cyc(); clr();
        chk("tclr", 16'(Tstep), 16'd0);
        load(7, 16'hFFFF);
        IncrPc = 1; cyc(); clr();
        pkc(7, 16'h0000);
        load(7, 16'h0005);
        IncrPc = 1; Rin = 8'h80; DINout = 1; DIN = 16'h0040; cyc(); clr();
        pkc(7, 16'h0040);
        load(7, 16'h0010);
        DIN = 16'h01CB; IRin = 1; ADDRin = 1; cyc(); clr();
        chk("ir_1cb", 16'(Instrucao), 16'h01CB);
        chk("addr_pc", ADDR, 16'h0010);
        load(4, 16'h0033);
        Rout = 8'h10; ADDRin = 1; DOUTin = 1; W_D = 1; cyc(); clr();
        chk("addr_33", ADDR, 16'h0033);
        chk("dout_33", DOUT, 16'h0033);
        chk("w_1", 16'(W), 16'h1);
        for (int n = 0; n < 300; n++) begin
            clr();
            if (n % 8 == 0) peek_all();
            Resetn = ($urandom_range(0, 40) != 0);
            DIN = 16'($urandom);
            Run = ($urandom_range(0, 3) == 0);
            Clear = ($urandom_range(0, 7) == 0);
            IncrPc = $urandom_range(0, 1) == 1;
            IRin = $urandom_range(0, 1) == 1;
            Rin = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom) & 8'($urandom);
            Rout = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) Rout = 0;
            Ain = $urandom_range(0, 1) == 1;
            Gin = $urandom_range(0, 1) == 1;
            Gout = ($urandom_range(0, 4) == 0);
            Ulaop = 2'($urandom);
            DINout = ($urandom_range(0, 3) == 0);
            ADDRin = $urandom_range(0, 1) == 1;
            DOUTin = $urandom_range(0, 1) == 1;
            W_D = $urandom_range(0, 1) == 1;
            cyc();
        end
        Resetn = 1; clr();
        peek_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
